inst_issue_unit: RTL and testbench
==================================

INST_ISSUE_UNIT -- requirements
Module: inst_issue_unit

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low, and the ports are named clk and reset as elsewhere in the codebase.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- WORD_SIZE, 32, instruction width.
- RB_INDEX, 4, reorder-buffer index width.
- FU_INDEX, 4, FU number width.
- ADDER_NUM, 3, MULTER_NUM, 2, LOADER_NUM, 3, BRANCH_NUM, 1, STORER_NUM, 2: FU counts per class.
- IQ_DEPTH, 4, instruction queue depth (power of 2).
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock.
- reset, in, 1, async active-low reset.
- fetch_valid, in, 1, fetch offers fetch_inst.
- fetch_inst, in, WORD_SIZE, instruction word.
- fetch_ready, out, 1, queue accepts a word.
- busy, in, FU_NUM, per-FU reservation-station busy.
- rb_full, in, 1, reorder buffer has no free entry.
- rb_tail, in, RB_INDEX, next free RB entry.
- flush, in, 1, mispredict flush.
- CDB_inst_fu, out, FU_INDEX, target FU.
- CDB_inst_inst, out, WORD_SIZE, issued instruction.
- CDB_inst_RBindex, out, RB_INDEX, allocated RB entry.
- issue_valid, out, 1, CDB_inst carries an issue this cycle.
- illegal_op, out, 1, one-cycle pulse when an undecodable opcode is dropped.
- issue_state, out, 2, FSM state.

Function
REQ-004 The block SHALL define FU_NUM as the sum of the per-class FU counts, with FU numbers assigned in this order: adders, multers, loaders, branch, storers. Storers occupy FU_NUM-STORER_NUM through FU_NUM-1.
REQ-005 The block SHALL decode the opcode from inst[31:26] as follows: ADD/SUB go to the adders, MUL to the multers, LD to the loaders, BEQ to the branch unit, ST to the storers; any other opcode is illegal.
REQ-006 The block SHALL hold instructions in a FIFO queue of IQ_DEPTH entries with wrapping pointers. A push occurs on fetch_valid && fetch_ready, and fetch_ready = !full.
REQ-007 The block SHALL treat an FU as free when its busy bit is 0 and it was not the FU issued in the previous cycle, because the RS busy bit rises one cycle late.
REQ-008 The block SHALL select the lowest-numbered free FU within the head instruction's class.
REQ-009 The block SHALL issue when the head entry is valid, rb_full=0 and a free FU exists. On issue, the block registers fu, the instruction and rb_tail onto the CDB_inst outputs, asserts issue_valid for exactly one cycle, and pops the head.
REQ-010 The block SHALL allow a word pushed into an empty queue at edge N to appear on CDB_inst at edge N+1 at the earliest.
REQ-011 The block SHALL drive CDB_inst_fu to all-ones (NULL), CDB_inst_inst to 0 and issue_valid to 0 whenever it does not issue.
REQ-012 The block SHALL pop an illegal head without issuing, pulse illegal_op for one cycle, and leave the RB untouched.
REQ-013 The block SHALL implement an FSM with four states:
- EMPTY (0): queue empty.
- READY (1): head issuable.
- STALL_RB (2): head valid and rb_full=1; this state takes priority over STALL_FU.
- STALL_FU (3): head valid and no free FU in its class.
The state is re-evaluated every cycle from the post-update queue.
REQ-014 The block SHALL, on flush, empty the queue at that edge, ignore any push in the same cycle, force issue_valid=0 for that cycle, and enter EMPTY.
REQ-015 The block SHALL issue at most one instruction per cycle. A simultaneous push and pop SHALL keep the queue count unchanged.

Reset
REQ-016 The block SHALL, while reset=0, immediately:
- clear the queue and pointers;
- set issue_valid=0 and illegal_op=0;
- set CDB_inst_fu=NULL, CDB_inst_inst=0 and CDB_inst_RBindex=0;
- clear the last-issued FU mask;
- set issue_state=EMPTY;
- set fetch_ready=1.
An issue in progress when reset asserts is discarded.

Configuration
REQ-017 When ISSUE_PERF_EN is defined, the block SHALL add 32-bit outputs issue_count and stall_count. issue_count increments per issue, stall_count increments per cycle in STALL_RB or STALL_FU, both wrap at 2^32, and both clear on reset. When the macro is not defined, these ports and counters SHALL be absent.

Structure
REQ-018 The opcode constants, FU class enumeration, NULL FU value and issue_state encoding SHALL live in the shared parameters package.
REQ-019 The FIFO SHALL be a single sub-module named issue_queue, and decode plus free-FU selection SHALL be combinational logic in the top module.

Verification
REQ-020 The bench SHALL cover these directed scenarios (stimulus -> required response):
- ADD pushed with busy=0 and rb_tail=5 -> next cycle CDB_inst_fu=0, CDB_inst_RBindex=5, issue_valid=1 for one cycle.
- Two back-to-back ADDs while busy stays 0 -> fu=0, then fu=1 (mask of last-issued FU).
- MUL with busy[4:3]=2'b11 -> STALL_FU; clearing busy[3] -> issue to fu=3.
- rb_full=1 with a valid head -> STALL_RB and no issue; rb_full=0 -> issue next cycle.
- Fill 4 entries -> fetch_ready=0; flush -> queue empty, EMPTY, fetch_ready=1; opcode 63 -> illegal_op pulse and no issue.
- reset driven low mid-stall -> all outputs at reset values immediately; with ISSUE_PERF_EN, 3 stall cycles plus 2 issues -> stall_count=3, issue_count=2.

Source files
------------

// File: rtl/inst_issue_unit_pkg.sv
// Shared definitions for the instruction issue unit: opcode map, FU classes,
// the NULL FU marker and the issue_state encoding.
package inst_issue_unit_pkg;

    localparam logic [5:0] OP_ADD = 6'h01;
    localparam logic [5:0] OP_SUB = 6'h02;
    localparam logic [5:0] OP_MUL = 6'h03;
    localparam logic [5:0] OP_LD  = 6'h04;
    localparam logic [5:0] OP_BEQ = 6'h05;
    localparam logic [5:0] OP_ST  = 6'h06;

    // NULL FU is the all-ones FU number; replicate this bit to the FU width
    localparam logic FU_NULL_BIT = 1'b1;

    typedef enum logic [2:0] {
        CLS_ADD, CLS_MUL, CLS_LD, CLS_BR, CLS_ST, CLS_ILL
    } fu_class_e;

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_READY    = 2'd1,
        ST_STALL_RB = 2'd2,
        ST_STALL_FU = 2'd3
    } issue_state_e;

    function automatic fu_class_e decode_class(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB: return CLS_ADD;
            OP_MUL:         return CLS_MUL;
            OP_LD:          return CLS_LD;
            OP_BEQ:         return CLS_BR;
            OP_ST:          return CLS_ST;
            default:        return CLS_ILL;
        endcase
    endfunction

endpackage

// File: rtl/inst_issue_unit_if.sv
// Fetch / RS / RB / CDB signal bundle of the issue unit.
// slave = the issue unit, master = its environment.
// ISSUE_PERF_EN adds the issue_count / stall_count outputs.
interface inst_issue_unit_if #(
    parameter int WORD_SIZE = 32,
    parameter int RB_INDEX  = 4,
    parameter int FU_INDEX  = 4,
    parameter int FU_NUM    = 11
);
    logic                 fetch_valid;
    logic [WORD_SIZE-1:0] fetch_inst;
    logic                 fetch_ready;
    logic [FU_NUM-1:0]    busy;
    logic                 rb_full;
    logic [RB_INDEX-1:0]  rb_tail;
    logic                 flush;
    logic [FU_INDEX-1:0]  CDB_inst_fu;
    logic [WORD_SIZE-1:0] CDB_inst_inst;
    logic [RB_INDEX-1:0]  CDB_inst_RBindex;
    logic                 issue_valid;
    logic                 illegal_op;
    logic [1:0]           issue_state;
`ifdef ISSUE_PERF_EN
    logic [31:0]          issue_count;
    logic [31:0]          stall_count;

    modport master (
        output fetch_valid, fetch_inst, busy, rb_full, rb_tail, flush,
        input  fetch_ready, CDB_inst_fu, CDB_inst_inst, CDB_inst_RBindex,
               issue_valid, illegal_op, issue_state, issue_count, stall_count
    );
    modport slave (
        input  fetch_valid, fetch_inst, busy, rb_full, rb_tail, flush,
        output fetch_ready, CDB_inst_fu, CDB_inst_inst, CDB_inst_RBindex,
               issue_valid, illegal_op, issue_state, issue_count, stall_count
    );
`else
    modport master (
        output fetch_valid, fetch_inst, busy, rb_full, rb_tail, flush,
        input  fetch_ready, CDB_inst_fu, CDB_inst_inst, CDB_inst_RBindex,
               issue_valid, illegal_op, issue_state
    );
    modport slave (
        input  fetch_valid, fetch_inst, busy, rb_full, rb_tail, flush,
        output fetch_ready, CDB_inst_fu, CDB_inst_inst, CDB_inst_RBindex,
               issue_valid, illegal_op, issue_state
    );
`endif
endinterface

// File: rtl/inst_issue_unit_issue_queue.sv
// In-order instruction FIFO with wrapping pointers. Besides the head it
// exposes the top KEY_W bits (opcode field) of the head as it will be after
// this edge, so the owner can register a state derived from the updated queue.
module issue_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int KEY_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_head,
    output logic             o_head_vld,
    output logic             o_full,
    output logic [KEY_W-1:0] o_nxt_key,
    output logic             o_nxt_vld
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr, r_rd;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;

    assign o_head     = r_mem[r_rd];
    assign o_head_vld = (r_cnt != '0);
    assign o_full     = (r_cnt == CW'(DEPTH));
    assign o_nxt_vld  = (w_cnt_nxt != '0);

    // next occupancy and the opcode field of the post-edge head
    always_comb begin
        w_cnt_nxt = r_cnt + CW'(i_push) - CW'(i_pop);
        if (i_flush)
            w_cnt_nxt = '0;
        o_nxt_key = r_mem[r_rd][WIDTH-1 -: KEY_W];
        if (i_pop)
            o_nxt_key = (r_cnt == CW'(1)) ? i_data[WIDTH-1 -: KEY_W]
                                          : r_mem[r_rd + PW'(1)][WIDTH-1 -: KEY_W];
        else if (r_cnt == '0)
            o_nxt_key = i_data[WIDTH-1 -: KEY_W];
    end

    // storage; contents are don't-care while the count says empty
    always_ff @(posedge clk) begin
        if (i_push)
            r_mem[r_wr] <= i_data;
    end

    // pointers and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else if (i_flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + PW'(1);
            if (i_pop)  r_rd <= r_rd + PW'(1);
            r_cnt <= w_cnt_nxt;
        end
    end
endmodule

// File: rtl/inst_issue_unit.sv
// Instruction issue unit: decodes the queue head, picks the lowest free FU of
// its class and registers the issue onto the CDB_inst outputs.
// Optional build macro ISSUE_PERF_EN adds issue/stall counters.
module inst_issue_unit
    import inst_issue_unit_pkg::*;
#(
    parameter int WORD_SIZE  = 32,
    parameter int RB_INDEX   = 4,
    parameter int FU_INDEX   = 4,
    parameter int ADDER_NUM  = 3,
    parameter int MULTER_NUM = 2,
    parameter int LOADER_NUM = 3,
    parameter int BRANCH_NUM = 1,
    parameter int STORER_NUM = 2,
    parameter int IQ_DEPTH   = 4
) (
    input logic           clk,
    input logic           reset,
    inst_issue_unit_if.slave bus
);
    localparam int MUL_BASE = ADDER_NUM;
    localparam int LD_BASE  = MUL_BASE + MULTER_NUM;
    localparam int BR_BASE  = LD_BASE + LOADER_NUM;
    localparam int ST_BASE  = BR_BASE + BRANCH_NUM;
    localparam int FU_NUM   = ST_BASE + STORER_NUM;
    localparam logic [FU_INDEX-1:0] FU_NULL = {FU_INDEX{FU_NULL_BIT}};

    // {found, fu}: lowest free FU inside the opcode's class range
    function automatic logic [FU_INDEX:0] pick_fu(input logic [5:0] op,
                                                  input logic [FU_NUM-1:0] free);
        int lo, hi;
        logic [FU_INDEX:0] res;
        res = {1'b0, FU_NULL};
        lo  = 0;
        hi  = 0;
        case (decode_class(op))
            CLS_ADD: begin lo = 0;        hi = MUL_BASE; end
            CLS_MUL: begin lo = MUL_BASE; hi = LD_BASE;  end
            CLS_LD:  begin lo = LD_BASE;  hi = BR_BASE;  end
            CLS_BR:  begin lo = BR_BASE;  hi = ST_BASE;  end
            CLS_ST:  begin lo = ST_BASE;  hi = FU_NUM;   end
            default: begin lo = 0;        hi = 0;        end
        endcase
        for (int i = FU_NUM - 1; i >= 0; i--)
            if (i >= lo && i < hi && free[i])
                res = {1'b1, FU_INDEX'(i)};
        return res;
    endfunction

    logic [WORD_SIZE-1:0] w_head;
    logic                 w_head_vld, w_full, w_nxt_vld;
    logic [5:0]           w_nxt_op;
    logic [FU_NUM-1:0]    w_free, w_mask_nxt;
    logic [FU_INDEX:0]    w_pick, w_nxt_pick;
    logic                 w_issue, w_illegal, w_push, w_pop;
    issue_state_e         r_state, w_state_nxt;

    logic [FU_NUM-1:0]    r_last_mask;
    logic [FU_INDEX-1:0]  r_fu;
    logic [WORD_SIZE-1:0] r_inst;
    logic [RB_INDEX-1:0]  r_rb;
    logic                 r_vld, r_ill;

    issue_queue #(.WIDTH(WORD_SIZE), .DEPTH(IQ_DEPTH), .KEY_W(6)) u_iq (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_push),
        .i_pop      (w_pop),
        .i_flush    (bus.flush),
        .i_data     (bus.fetch_inst),
        .o_head     (w_head),
        .o_head_vld (w_head_vld),
        .o_full     (w_full),
        .o_nxt_key  (w_nxt_op),
        .o_nxt_vld  (w_nxt_vld)
    );

    // the RS busy bit lags one cycle, so last cycle's target is also taken
    assign w_free     = ~bus.busy & ~r_last_mask;
    assign w_pick     = pick_fu(w_head[31:26], w_free);
    assign w_illegal  = w_head_vld && !bus.flush && (decode_class(w_head[31:26]) == CLS_ILL);
    assign w_issue    = w_head_vld && !bus.flush && !bus.rb_full && w_pick[FU_INDEX];
    assign w_pop      = w_issue || w_illegal;
    assign w_push     = bus.fetch_valid && !w_full && !bus.flush;
    assign w_mask_nxt = w_issue ? (FU_NUM'(1) << w_pick[FU_INDEX-1:0]) : '0;
    assign w_nxt_pick = pick_fu(w_nxt_op, ~bus.busy & ~w_mask_nxt);

    // classify the head that will be present after this edge
    always_comb begin
        w_state_nxt = ST_EMPTY;
        if (!bus.flush && w_nxt_vld) begin
            if (bus.rb_full)
                w_state_nxt = ST_STALL_RB;
            else if (!w_nxt_pick[FU_INDEX])
                w_state_nxt = ST_STALL_FU;
            else
                w_state_nxt = ST_READY;
        end
    end

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_EMPTY;
        else        r_state <= w_state_nxt;
    end

    // CDB_inst outputs: valid for one cycle per issue, NULL/zero otherwise
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fu        <= FU_NULL;
            r_inst      <= '0;
            r_rb        <= '0;
            r_vld       <= 1'b0;
            r_ill       <= 1'b0;
            r_last_mask <= '0;
        end else begin
            r_fu        <= w_issue ? w_pick[FU_INDEX-1:0] : FU_NULL;
            r_inst      <= w_issue ? w_head : '0;
            r_rb        <= w_issue ? bus.rb_tail : '0;
            r_vld       <= w_issue;
            r_ill       <= w_illegal;
            r_last_mask <= w_mask_nxt;
        end
    end

    assign bus.fetch_ready      = !w_full;
    assign bus.CDB_inst_fu      = r_fu;
    assign bus.CDB_inst_inst    = r_inst;
    assign bus.CDB_inst_RBindex = r_rb;
    assign bus.issue_valid      = r_vld;
    assign bus.illegal_op       = r_ill;
    assign bus.issue_state      = r_state;

`ifdef ISSUE_PERF_EN
    logic [31:0] r_issue_cnt, r_stall_cnt;

    // free-running wrap-around counters of issues and stalled cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_issue_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_issue)
                r_issue_cnt <= r_issue_cnt + 32'd1;
            if (r_state == ST_STALL_RB || r_state == ST_STALL_FU)
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign bus.issue_count = r_issue_cnt;
    assign bus.stall_count = r_stall_cnt;
`endif
endmodule

// File: tb/tb_inst_issue_unit.sv
// Scoreboard bench for inst_issue_unit: a queue-based reference model predicts
// each issue at the clock edge, a negedge monitor compares DUT outputs.
module tb_inst_issue_unit;
    import inst_issue_unit_pkg::*;

    localparam int FU_NUM = 11;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    inst_issue_unit_if #(.WORD_SIZE(32), .RB_INDEX(4), .FU_INDEX(4), .FU_NUM(FU_NUM)) bus ();

    inst_issue_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [3:0]  fu;
        logic [31:0] inst;
        logic [3:0]  rb;
    } iss_t;

    iss_t        sb[$];
    logic [31:0] mq[$];
    int          last_fu     = -1;
    int          m_state     = 0;
    bit          m_vld       = 0;
    bit          m_ill       = 0;
    bit          m_ready     = 1;
    int          m_iss_cnt   = 0;
    int          m_stall_cnt = 0;

    // FU ranges: adders 0-2, multers 3-4, loaders 5-7, branch 8, storers 9-10
    function automatic void cls_range(input logic [5:0] op, output int lo, output int hi);
        lo = 0; hi = 0;
        if (op == OP_ADD || op == OP_SUB) begin lo = 0; hi = 3;  end
        else if (op == OP_MUL)            begin lo = 3; hi = 5;  end
        else if (op == OP_LD)             begin lo = 5; hi = 8;  end
        else if (op == OP_BEQ)            begin lo = 8; hi = 9;  end
        else if (op == OP_ST)             begin lo = 9; hi = 11; end
    endfunction

    function automatic int free_fu(input int lo, input int hi,
                                   input logic [FU_NUM-1:0] busy, input int last);
        for (int f = lo; f < hi; f++)
            if (!busy[f] && f != last) return f;
        return -1;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            sb.delete();
            last_fu = -1; m_state = 0; m_vld = 0; m_ill = 0; m_ready = 1;
            m_iss_cnt = 0; m_stall_cnt = 0;
        end else begin
            bit push;
            int lo, hi, f, nf;
            if (m_state >= 2) m_stall_cnt++;
            push  = bus.fetch_valid && (mq.size() < 4) && !bus.flush;
            m_vld = 0; m_ill = 0; nf = -1;
            if (bus.flush) begin
                mq.delete();
            end else if (mq.size() > 0) begin
                cls_range(mq[0][31:26], lo, hi);
                if (lo == hi) begin
                    m_ill = 1;
                    void'(mq.pop_front());
                end else if (!bus.rb_full) begin
                    f = free_fu(lo, hi, bus.busy, last_fu);
                    if (f >= 0) begin
                        sb.push_back(iss_t'{fu: 4'(f), inst: mq[0], rb: bus.rb_tail});
                        m_vld = 1; m_iss_cnt++; nf = f;
                        void'(mq.pop_front());
                    end
                end
            end
            last_fu = nf;
            if (push) mq.push_back(bus.fetch_inst);
            if (mq.size() == 0) m_state = 0;
            else if (bus.rb_full) m_state = 2;
            else begin
                cls_range(mq[0][31:26], lo, hi);
                m_state = (free_fu(lo, hi, bus.busy, last_fu) >= 0) ? 1 : 3;
            end
            m_ready = (mq.size() < 4);
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        iss_t e;
        chk("issue_valid", bus.issue_valid, m_vld);
        chk("illegal_op",  bus.illegal_op,  m_ill);
        chk("issue_state", bus.issue_state, m_state);
        chk("fetch_ready", bus.fetch_ready, m_ready);
        if (bus.issue_valid) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_unexpected_issue got fu %0h expected no issue", bus.CDB_inst_fu);
            end else begin
                e = sb.pop_front();
                chk("cdb_fu",      bus.CDB_inst_fu,      e.fu);
                chk("cdb_inst",    bus.CDB_inst_inst,    e.inst);
                chk("cdb_rbindex", bus.CDB_inst_RBindex, e.rb);
            end
        end else begin
            chk("cdb_fu_null",   bus.CDB_inst_fu,   4'hF);
            chk("cdb_inst_zero", bus.CDB_inst_inst, 32'h0);
        end
`ifdef ISSUE_PERF_EN
        chk("issue_count", bus.issue_count, m_iss_cnt);
        chk("stall_count", bus.stall_count, m_stall_cnt);
`endif
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [25:0] lo);
        return {op, lo};
    endfunction

    logic [5:0] ops [6];

    initial begin
        ops = '{OP_ADD, OP_SUB, OP_MUL, OP_LD, OP_BEQ, OP_ST};
        bus.fetch_valid = 0; bus.fetch_inst = '0; bus.busy = '0;
        bus.rb_full = 0; bus.rb_tail = '0; bus.flush = 0;
        repeat (2) step();
        reset = 1;
        step();

        // single ADD: issues one cycle after the push, fu 0, RB 5
        bus.rb_tail = 4'd5;
        bus.fetch_valid = 1; bus.fetch_inst = mk(OP_ADD, 26'h11);
        step();
        bus.fetch_valid = 0;
        chk("d1_state_ready", bus.issue_state, 2'd1);
        step();
        chk("d1_valid", bus.issue_valid, 1'b1);
        chk("d1_fu", bus.CDB_inst_fu, 4'd0);
        chk("d1_rb", bus.CDB_inst_RBindex, 4'd5);
        step();
        chk("d1_valid_drop", bus.issue_valid, 1'b0);

        // back-to-back ADDs: last-issued mask pushes the second to fu 1
        bus.fetch_valid = 1; bus.fetch_inst = mk(OP_ADD, 26'h21);
        step();
        bus.fetch_inst = mk(OP_SUB, 26'h22);
        step();
        bus.fetch_valid = 0;
        chk("d2_fu_first", bus.CDB_inst_fu, 4'd0);
        step();
        chk("d2_fu_second", bus.CDB_inst_fu, 4'd1);
        chk("d2_inst_second", bus.CDB_inst_inst, mk(OP_SUB, 26'h22));
        step();

        // MUL with both multers busy stalls, then goes to fu 3
        bus.busy = 11'h018;
        bus.fetch_valid = 1; bus.fetch_inst = mk(OP_MUL, 26'h31);
        step();
        bus.fetch_valid = 0;
        step();
        chk("d3_stall_fu", bus.issue_state, 2'd3);
        chk("d3_no_issue", bus.issue_valid, 1'b0);
        bus.busy = 11'h010;
        step();
        chk("d3_valid", bus.issue_valid, 1'b1);
        chk("d3_fu", bus.CDB_inst_fu, 4'd3);
        bus.busy = '0;
        step();

        // RB full holds the head
        bus.rb_full = 1;
        bus.fetch_valid = 1; bus.fetch_inst = mk(OP_LD, 26'h41);
        step();
        bus.fetch_valid = 0;
        step();
        chk("d4_stall_rb", bus.issue_state, 2'd2);
        chk("d4_no_issue", bus.issue_valid, 1'b0);
        bus.rb_full = 0;
        step();
        chk("d4_valid", bus.issue_valid, 1'b1);
        chk("d4_fu", bus.CDB_inst_fu, 4'd5);
        step();

        // fill, flush, illegal opcode
        bus.rb_full = 1; bus.fetch_valid = 1;
        for (int k = 0; k < 4; k++) begin
            bus.fetch_inst = mk(OP_ADD, 26'(k));
            step();
        end
        bus.fetch_valid = 0;
        chk("d5_full_not_ready", bus.fetch_ready, 1'b0);
        bus.flush = 1;
        step();
        bus.flush = 0;
        chk("d5_flush_empty", bus.issue_state, 2'd0);
        chk("d5_flush_ready", bus.fetch_ready, 1'b1);
        bus.rb_full = 0;
        bus.fetch_valid = 1; bus.fetch_inst = mk(6'd63, 26'h5);
        step();
        bus.fetch_valid = 0;
        step();
        chk("d5_illegal_pulse", bus.illegal_op, 1'b1);
        chk("d5_illegal_no_issue", bus.issue_valid, 1'b0);
        step();
        chk("d5_illegal_drop", bus.illegal_op, 1'b0);

        // asynchronous reset in the middle of a stall
        bus.rb_full = 1;
        bus.fetch_valid = 1; bus.fetch_inst = mk(OP_ST, 26'h61);
        step();
        bus.fetch_valid = 0;
        step();
        step();
        reset = 0;
        #1;
        chk("d6_rst_state", bus.issue_state, 2'd0);
        chk("d6_rst_ready", bus.fetch_ready, 1'b1);
        chk("d6_rst_valid", bus.issue_valid, 1'b0);
        chk("d6_rst_illegal", bus.illegal_op, 1'b0);
        chk("d6_rst_fu", bus.CDB_inst_fu, 4'hF);
        chk("d6_rst_inst", bus.CDB_inst_inst, 32'h0);
        chk("d6_rst_rb", bus.CDB_inst_RBindex, 4'h0);
        step();
        reset = 1;
        step();

        // three stalled cycles followed by two issues
        bus.fetch_valid = 1; bus.fetch_inst = mk(OP_ADD, 26'h71);
        step();
        bus.fetch_valid = 0;
        step();
        step();
        bus.rb_full = 0;
        bus.fetch_valid = 1; bus.fetch_inst = mk(OP_ADD, 26'h72);
        step();
        bus.fetch_valid = 0;
        step();
        step();
`ifdef ISSUE_PERF_EN
        chk("d7_stall_count", bus.stall_count, 32'd3);
        chk("d7_issue_count", bus.issue_count, 32'd2);
`endif

        // randomized traffic
        for (int n = 0; n < 2500; n++) begin
            bus.fetch_valid = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 19) == 0)
                bus.fetch_inst = {6'($urandom_range(7, 63)), 26'($urandom)};
            else
                bus.fetch_inst = {ops[$urandom_range(0, 5)], 26'($urandom)};
            for (int b = 0; b < FU_NUM; b++)
                bus.busy[b] = ($urandom_range(0, 3) == 0);
            bus.rb_full = ($urandom_range(0, 6) == 0);
            bus.rb_tail = 4'($urandom);
            bus.flush   = ($urandom_range(0, 39) == 0);
            reset       = ($urandom_range(0, 499) != 0);
            step();
        end

        reset = 1; bus.flush = 0; bus.fetch_valid = 0;
        bus.busy = '0; bus.rb_full = 0;
        repeat (8) step();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
